// File: rtl/model_trainer_pkg.sv
// Shared definitions for the model trainer parameter-update blocks.
// Holds FSM state encodings and common fixed-point constants.
package model_trainer_pkg;

  localparam int DEFAULT_DATA_SIZE     = 64;
  localparam int DEFAULT_FRACTION_SIZE = 32;

  localparam logic [DEFAULT_DATA_SIZE-1:0] ZERO_DATA = '0;
  localparam logic [DEFAULT_DATA_SIZE-1:0] ONE_DATA  = DEFAULT_DATA_SIZE'(1);

  typedef enum logic [1:0] {
    STARTER_STATE,
    INPUT_STATE,
    DRAIN_STATE,
    ENDER_STATE
  } updater_state_t;

endpackage

// File: rtl/model_parameter_updater_datapath.sv
// Two-stage P - ETA*G pipeline: stage 1 scales the gradient, stage 2 subtracts.
// Valid and row-first flags travel alongside the data.
module model_parameter_updater_datapath #(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic [DATA_SIZE-1:0] eta,
  input  logic [DATA_SIZE-1:0] gradient,
  input  logic [DATA_SIZE-1:0] parameter_in,
  output logic                 out_valid,
  output logic                 out_first,
  output logic [DATA_SIZE-1:0] data_out
);

  logic signed [2*DATA_SIZE-1:0] product;
  logic        [DATA_SIZE-1:0]   scaled;

  logic                 s1_valid;
  logic                 s1_first;
  logic [DATA_SIZE-1:0] s1_scaled;
  logic [DATA_SIZE-1:0] s1_parameter;

  assign product = $signed(gradient) * $signed(eta);
  // Arithmetic shift then truncate keeps the fixed-point binary point aligned.
  assign scaled  = DATA_SIZE'(product >>> FRACTION_SIZE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_scaled    <= '0;
      s1_parameter <= '0;
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      data_out     <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_first  <= in_valid & in_first;
      if (in_valid) begin
        s1_scaled    <= scaled;
        s1_parameter <= parameter_in;
      end
      out_valid <= s1_valid;
      out_first <= s1_valid & s1_first;
      if (s1_valid) begin
        data_out <= s1_parameter - s1_scaled;
      end
    end
  end

endmodule

// File: rtl/model_parameter_updater.sv
// Applies P_new = P - ETA*G to one gradient stream, L rows of X elements.
// FSM and row/element counters live here; arithmetic is in the datapath.
module model_parameter_updater
  import model_trainer_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 4,
  parameter int FRACTION_SIZE = DEFAULT_FRACTION_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_L_ENABLE,
  input  logic                 DATA_IN_X_ENABLE,
  output logic                 DATA_OUT_L_ENABLE,
  output logic                 DATA_OUT_X_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_L_IN,
  input  logic [DATA_SIZE-1:0] SIZE_X_IN,
  input  logic [DATA_SIZE-1:0] ETA_IN,
  input  logic [DATA_SIZE-1:0] G_IN,
  input  logic [DATA_SIZE-1:0] P_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);
  localparam int unused_control_size = CONTROL_SIZE;

  updater_state_t       state;
  logic [DATA_SIZE-1:0] size_l;
  logic [DATA_SIZE-1:0] size_x;
  logic [DATA_SIZE-1:0] eta;
  logic [DATA_SIZE-1:0] index_l;
  logic [DATA_SIZE-1:0] index_x;

  logic accept;
  logic first;
  logic last_x;
  logic last_l;
  logic unused_inputs;

  assign unused_inputs = DATA_IN_L_ENABLE;

  assign accept = (state == INPUT_STATE) && DATA_IN_X_ENABLE;
  assign first  = (index_x == '0);
  assign last_x = (index_x == size_x - ONE);
  assign last_l = (index_l == size_l - ONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= STARTER_STATE;
      READY   <= 1'b0;
      size_l  <= '0;
      size_x  <= '0;
      eta     <= '0;
      index_l <= '0;
      index_x <= '0;
    end else begin
      READY <= 1'b0;
      case (state)
        STARTER_STATE: begin
          if (START) begin
            size_l  <= SIZE_L_IN;
            size_x  <= SIZE_X_IN;
            eta     <= ETA_IN;
            index_l <= '0;
            index_x <= '0;
            if (SIZE_L_IN == '0 || SIZE_X_IN == '0) begin
              state <= ENDER_STATE;
            end else begin
              state <= INPUT_STATE;
            end
          end
        end
        INPUT_STATE: begin
          if (accept) begin
            if (last_x) begin
              index_x <= '0;
              if (last_l) begin
                state <= DRAIN_STATE;
              end else begin
                index_l <= index_l + ONE;
              end
            end else begin
              index_x <= index_x + ONE;
            end
          end
        end
        DRAIN_STATE: begin
          // Only the final element remains, in stage 1; it reaches DATA_OUT on
          // this edge, so READY (registered in ENDER) follows that output.
          state <= ENDER_STATE;
        end
        ENDER_STATE: begin
          READY <= 1'b1;
          state <= STARTER_STATE;
        end
        default: state <= STARTER_STATE;
      endcase
    end
  end

  model_parameter_updater_datapath #(
    .DATA_SIZE    (DATA_SIZE),
    .FRACTION_SIZE(FRACTION_SIZE)
  ) datapath (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (accept),
    .in_first    (first),
    .eta         (eta),
    .gradient    (G_IN),
    .parameter_in(P_IN),
    .out_valid   (DATA_OUT_X_ENABLE),
    .out_first   (DATA_OUT_L_ENABLE),
    .data_out    (DATA_OUT)
  );

endmodule
